// File: rtl/graycode_pkg.sv
// graycode_pkg
//   Shared definitions for gray-coded ramp readout and for any block that
//   consumes the upstream gray counter.
//   - state_e  : readout controller states (IDLE, CONVERT, READOUT)
//   - bin2gray : binary -> reflected gray, up to 32 bits
//   - gray2bin : reflected gray -> binary, up to 32 bits
//   Narrower values can be zero-extended into these functions; leading zero
//   gray bits decode to leading zero binary bits, so results stay correct.
package graycode_pkg;

  localparam int GRAY_FN_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READOUT = 2'd2
  } state_e;

  // Each gray bit is the XOR of the matching binary bit and the one above it.
  function automatic logic [GRAY_FN_WIDTH-1:0] bin2gray(input logic [GRAY_FN_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Decode from the MSB downwards: each binary bit folds in the next gray bit.
  function automatic logic [GRAY_FN_WIDTH-1:0] gray2bin(input logic [GRAY_FN_WIDTH-1:0] gray);
    logic [GRAY_FN_WIDTH-1:0] bin;
    bin = '0;
    bin[GRAY_FN_WIDTH-1] = gray[GRAY_FN_WIDTH-1];
    for (int k = GRAY_FN_WIDTH - 2; k >= 0; k--) begin
      bin[k] = bin[k+1] ^ gray[k];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// gray2bin
//   Purely combinational gray-to-binary decoder used on the readout data path.
//   Ports:
//     i_gray [WIDTH-1:0] : reflected gray code in
//     o_bin  [WIDTH-1:0] : binary value out
module gray2bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Binary bit k is the XOR of gray bits k..WIDTH-1, which is the unrolled
  // form of b[k] = b[k+1] ^ g[k]. Written as a reduction per bit so no bit of
  // o_bin depends on another bit of o_bin inside the block.
  always_comb begin
    o_bin = '0;
    for (int k = 0; k < WIDTH; k++) begin
      o_bin[k] = ^(i_gray >> k);
    end
  end

endmodule

// File: rtl/gray_readout.sv
// gray_readout
//   Single-slope ADC style readout. During CONVERT a shared gray-coded ramp
//   count is captured per pixel on the first cycle that pixel's comparator
//   trips. Pixels that never trip read out as full scale. During READOUT the
//   captured codes are decoded to binary and streamed out one pixel per
//   valid/ready handshake, followed by a one-cycle done pulse.
//   Ports:
//     clk      : clock, all state on rising edge
//     reset    : synchronous, active-low reset
//     start    : begin a conversion (only acted on in IDLE)
//     gray_in  : gray-coded ramp count from the upstream gray counter
//     cmp      : per-pixel comparator outputs, 1 = tripped
//     ready    : downstream sink accepts the current word
//     data     : decoded binary value of pixel pix_idx (registered)
//     pix_idx  : index of the pixel currently on data (registered)
//     valid    : data/pix_idx hold a word (registered)
//     busy     : high while converting or reading out (registered)
//     done     : one-cycle pulse after the last word is accepted (registered)
module gray_readout
  import graycode_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NPIX        = 4,
  parameter int CONV_CYCLES = 2**WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        gray_in,
  input  logic [NPIX-1:0]         cmp,
  input  logic                    ready,
  output logic [WIDTH-1:0]        data,
  output logic [$clog2(NPIX)-1:0] pix_idx,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = $clog2(NPIX);
  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CONV_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  // Gray code of the all-ones binary value: MSB set, every other bit clear.
  localparam logic [WIDTH-1:0] FULL_SCALE_GRAY = {1'b1, {(WIDTH-1){1'b0}}};

  state_e                       r_state;
  state_e                       w_stateNext;
  logic [NPIX-1:0]              r_tripped;
  logic [NPIX-1:0]              w_trippedNext;
  logic [NPIX-1:0]              w_tripNow;
  logic [NPIX-1:0]              w_trippedCapt;
  logic [NPIX-1:0][WIDTH-1:0]   r_mem;
  logic [NPIX-1:0][WIDTH-1:0]   w_memNext;
  logic [NPIX-1:0][WIDTH-1:0]   w_memCapt;
  logic [NPIX-1:0][WIDTH-1:0]   w_memExit;
  logic [CNT_W-1:0]             r_cnt;
  logic [CNT_W-1:0]             w_cntNext;
  logic [IDX_W-1:0]             r_pixIdx;
  logic [IDX_W-1:0]             w_pixIdxNext;
  logic [IDX_W-1:0]             w_nextIdx;
  logic [WIDTH-1:0]             r_data;
  logic [WIDTH-1:0]             w_dataNext;
  logic [WIDTH-1:0]             w_decIn;
  logic [WIDTH-1:0]             w_decBin;
  logic                         r_valid;
  logic                         w_validNext;
  logic                         r_busy;
  logic                         w_busyNext;
  logic                         r_done;
  logic                         w_doneNext;
  logic                         w_convExit;
  logic                         w_xfer;
  logic                         w_lastXfer;

  // Capture path. A pixel captures only on its first trip inside CONVERT;
  // once its flag is set the comparator is masked off, so glitches and
  // deassertion cannot overwrite the stored code. All pixels tripping in the
  // same cycle see the same gray_in. w_memExit is what the memory should hold
  // if this is the last CONVERT cycle: captures from this very edge are kept,
  // and anything still untripped is pinned to full scale.
  always_comb begin
    w_tripNow     = '0;
    w_trippedCapt = '0;
    w_memCapt     = '0;
    w_memExit     = '0;
    if (r_state == ST_CONVERT) begin
      w_tripNow = cmp & ~r_tripped;
    end
    w_trippedCapt = r_tripped | w_tripNow;
    for (int i = 0; i < NPIX; i++) begin
      w_memCapt[i] = w_tripNow[i] ? gray_in : r_mem[i];
      w_memExit[i] = w_trippedCapt[i] ? w_memCapt[i] : FULL_SCALE_GRAY;
    end
  end

  // The window closes as soon as every pixel is (or is becoming) tripped, so
  // a simultaneous trip of the last pixels moves straight to READOUT at that
  // edge; otherwise it closes on the final counted cycle.
  assign w_convExit = (r_state == ST_CONVERT) &&
                      ((&w_trippedCapt) || (r_cnt == LAST_CNT));
  assign w_xfer     = (r_state == ST_READOUT) && r_valid && ready;
  assign w_lastXfer = w_xfer && (r_pixIdx == LAST_IDX);
  // Wrap explicitly so the memory is never indexed past NPIX-1 when NPIX is
  // not a power of two.
  assign w_nextIdx  = (r_pixIdx == LAST_IDX) ? '0 : r_pixIdx + 1'b1;

  // One shared decoder. On the CONVERT exit edge it decodes pixel 0 straight
  // from the memory image being written, so the first word is ready in the
  // first READOUT cycle; during READOUT it looks one pixel ahead so the next
  // word is loaded on the transfer edge without a bubble.
  assign w_decIn = w_convExit ? w_memExit[0] : r_mem[w_nextIdx];

  gray2bin #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .i_gray (w_decIn),
    .o_bin  (w_decBin)
  );

  // Next-state and next-output logic. Everything holds by default and only
  // the state-specific branches change it; done defaults low so it can only
  // ever be a single-cycle pulse.
  always_comb begin
    w_stateNext   = r_state;
    w_trippedNext = r_tripped;
    w_memNext     = r_mem;
    w_cntNext     = r_cnt;
    w_pixIdxNext  = r_pixIdx;
    w_dataNext    = r_data;
    w_validNext   = r_valid;
    w_doneNext    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_stateNext   = ST_CONVERT;
          w_trippedNext = '0;
          w_cntNext     = '0;
        end
      end
      ST_CONVERT: begin
        w_cntNext     = r_cnt + 1'b1;
        w_trippedNext = w_trippedCapt;
        w_memNext     = w_memCapt;
        if (w_convExit) begin
          w_stateNext  = ST_READOUT;
          w_memNext    = w_memExit;
          w_pixIdxNext = '0;
          w_dataNext   = w_decBin;
          w_validNext  = 1'b1;
        end
      end
      ST_READOUT: begin
        if (w_lastXfer) begin
          w_stateNext = ST_IDLE;
          w_validNext = 1'b0;
          w_doneNext  = 1'b1;
        end else if (w_xfer) begin
          w_pixIdxNext = w_nextIdx;
          w_dataNext   = w_decBin;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_validNext = 1'b0;
      end
    endcase
    w_busyNext = (w_stateNext != ST_IDLE);
  end

  // State and output registers. Reset wipes everything including the pixel
  // memory, which also aborts a conversion/readout without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_tripped <= '0;
      r_mem     <= '0;
      r_cnt     <= '0;
      r_pixIdx  <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_tripped <= w_trippedNext;
      r_mem     <= w_memNext;
      r_cnt     <= w_cntNext;
      r_pixIdx  <= w_pixIdxNext;
      r_data    <= w_dataNext;
      r_valid   <= w_validNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  assign data    = r_data;
  assign pix_idx = r_pixIdx;
  assign valid   = r_valid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: doc/gray_readout.md
GRAY_READOUT -- requirements
Module: gray_readout

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the gray code and data width in bits.
REQ-002 SHALL have parameter NPIX, default 4, giving the number of pixel channels.
REQ-003 SHALL have parameter CONV_CYCLES, default 2**WIDTH, giving the conversion window length in clock cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begins a conversion, honoured only in IDLE.
REQ-007 SHALL have port gray_in, input, WIDTH bits: gray-coded ramp count from the upstream gray counter.
REQ-008 SHALL have port cmp, input, NPIX bits: per-pixel comparator outputs; a 1 means the pixel has tripped.
REQ-009 SHALL have port ready, input, 1 bit: the downstream sink accepts data.
REQ-010 SHALL have port data, output, WIDTH bits: the decoded binary value of the current pixel.
REQ-011 SHALL have port pix_idx, output, $clog2(NPIX) bits: the index of the pixel on data.
REQ-012 SHALL have port valid, output, 1 bit: data and pix_idx hold a valid word.
REQ-013 SHALL have port busy, output, 1 bit: high in CONVERT and in READOUT.
REQ-014 SHALL have port done, output, 1 bit: a one-cycle pulse after the last word is accepted.

Function
REQ-015 SHALL implement the FSM states IDLE, CONVERT and READOUT.
REQ-016 SHALL go from IDLE to CONVERT on start=1, at the same edge clear all tripped flags and clear the cycle counter to 0.
REQ-017 SHALL, in CONVERT, increment the cycle counter every cycle.
REQ-018 SHALL, in CONVERT, latch gray_in into mem[i] and set tripped[i] on the first cycle cmp[i]=1 while tripped[i]=0.
REQ-019 SHALL ignore later cmp[i] activity, including deassertion and glitches, once tripped[i] is set.
REQ-020 SHALL, when several pixels trip in the same cycle, latch the same gray_in value into every one of them.
REQ-021 SHALL leave CONVERT for READOUT when all tripped flags are set, or when the cycle counter equals CONV_CYCLES-1, whichever comes first.
REQ-022 SHALL, at the CONVERT exit edge, load every untripped pixel with the gray code of 2**WIDTH-1 (that is, MSB=1, all other bits 0).
REQ-023 SHALL, at the CONVERT exit edge, also latch any pixel that trips on that same edge with gray_in.
REQ-024 SHALL, in READOUT, present pixels in order 0..NPIX-1, with data = the binary decode of mem[pix_idx], registered.
REQ-025 SHALL decode gray to binary as b[WIDTH-1]=g[WIDTH-1] and b[k]=b[k+1]^g[k], for k descending.
REQ-026 SHALL raise valid on the first READOUT cycle.
REQ-027 SHALL hold data, pix_idx and valid stable while valid=1 and ready=0.
REQ-028 SHALL treat valid=1 and ready=1 as a transfer, and advance pix_idx on the next cycle, with no bubble between words.
REQ-029 SHALL, on the transfer with pix_idx=NPIX-1, return to IDLE, drop valid and pulse done=1 for exactly one cycle.
REQ-030 SHALL ignore start while busy=1.
REQ-031 SHALL ignore cmp outside CONVERT.
REQ-032 SHALL ignore ready outside READOUT.
REQ-033 SHALL treat a start on the same cycle as done as a new conversion, entering CONVERT on the next edge.

Reset
REQ-034 SHALL, when reset=0 at a clock edge, force: state=IDLE, valid=0, busy=0, done=0, data=0, pix_idx=0, tripped=0, cycle counter=0 and mem=0.
REQ-035 SHALL abort any conversion or readout in progress when reset is asserted, and emit no done pulse.
REQ-036 SHALL produce no output activity until start=1 is seen after reset deasserts.

Structure
REQ-037 SHALL place the state enum type and a gray2bin/bin2gray function pair in shared package graycode_pkg, reusable by graycounter users.
REQ-038 SHALL instantiate a single combinational sub-module, gray2bin (parameter WIDTH), for the decode path.
REQ-039 SHALL register all outputs, with no combinational path from any input to any output.

Verification
REQ-040 SHALL cover: NPIX=4 with cmp bits tripping while gray_in=bin2gray(10/20/30/40) -> words 10,20,30,40 on pix_idx 0..3, then done pulses for one cycle.
REQ-041 SHALL cover: pixel 2 never trips -> the CONVERT window lasts exactly 256 cycles and pixel 2 reads out 255.
REQ-042 SHALL cover: all four pixels trip on the same cycle with gray_in=bin2gray(77) -> every word reads 77, and READOUT begins on the next cycle.
REQ-043 SHALL cover: ready held 0 for 5 cycles on word 1 -> data and pix_idx stay stable; no word is lost or duplicated.
REQ-044 SHALL cover: reset=0 in the middle of READOUT -> all outputs are 0 next cycle, no done pulse, and a new start works normally.
REQ-045 SHALL cover: cmp[0] toggles 1,0,1 -> only the first trip value is kept; start during busy has no effect.
